// File: rtl/avalon_pio_gpio.sv
// avalon_pio_gpio: parametrised Avalon-MM general-purpose I/O slave.
// Each pin has a data-out bit and a direction bit. Inputs are synchronised
// and edge-detected. Captured edges can raise a maskable interrupt.
// Define the macro PIO_BITSET_EN to add atomic set (addr 4) and clear
// (addr 5) registers for data_out. Without it, those addresses are reserved.
module avalon_pio_gpio #(
    parameter int               WIDTH       = 17,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '1,
    parameter int               EDGE_TYPE   = 0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] out_en,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef PIO_BITSET_EN
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

    logic [WIDTH-1:0] r_dataOut;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irqMask;
    logic [WIDTH-1:0] r_edgeCap;
    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_syncD;
    logic             r_irq;

    logic             w_write;
    logic [WIDTH-1:0] w_wrData;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_edgeClr;
    logic             w_unusedBits;

    // Only the low WIDTH bits of writedata are used. The reduction keeps the
    // upper bits referenced so that they do not appear as dangling inputs.
    assign w_write      = chipselect & ~write_n;
    assign w_wrData     = writedata[WIDTH-1:0];
    assign w_unusedBits = ^writedata;
    assign w_sync       = r_sync[SYNC_STAGES-1];
    assign w_edgeClr    = (w_write && address == ADDR_EDGECAP) ? w_wrData : '0;

    assign out_port = r_dataOut;
    assign out_en   = r_dir;
    assign irq      = r_irq;

    // Bring the asynchronous pins into the clock domain, plus one extra
    // stage so that edges can be detected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_syncD <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_syncD <= w_sync;
        end
    end

    // Select the per-bit edge detector that matches the configured edge type.
    always_comb begin
        w_edge = '0;
        if (EDGE_TYPE == 0) begin
            w_edge = w_sync & ~r_syncD;
        end else if (EDGE_TYPE == 1) begin
            w_edge = ~w_sync & r_syncD;
        end else begin
            w_edge = w_sync ^ r_syncD;
        end
    end

    // Output data register. When enabled, it also handles the atomic
    // set/clear writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dataOut <= RESET_VALUE;
        end else if (w_write && address == ADDR_DATA) begin
            r_dataOut <= w_wrData;
`ifdef PIO_BITSET_EN
        end else if (w_write && address == ADDR_OUTSET) begin
            r_dataOut <= r_dataOut | w_wrData;
        end else if (w_write && address == ADDR_OUTCLR) begin
            r_dataOut <= r_dataOut & ~w_wrData;
`else
        end else begin
            r_dataOut <= r_dataOut;
`endif
        end
    end

    // Direction and interrupt-mask registers are plain read/write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dir     <= DIR_RESET;
            r_irqMask <= '0;
        end else begin
            if (w_write && address == ADDR_DIR) begin
                r_dir <= w_wrData;
            end
            if (w_write && address == ADDR_IRQMASK) begin
                r_irqMask <= w_wrData;
            end
        end
    end

    // Edge capture is sticky. Writing a 1 clears a bit. A new edge on an
    // input pin in the same cycle overrides the clear, so no edge is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgeCap <= '0;
        end else begin
            r_edgeCap <= (r_edgeCap & ~w_edgeClr) | (w_edge & ~r_dir);
        end
    end

    // The interrupt is registered, so it follows edge capture one clock later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_edgeCap & r_irqMask);
        end
    end

    // Zero-wait-state read mux. On the DATA register, output pins read back
    // the driven value and input pins read back the synchronised pin.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:    readdata[WIDTH-1:0] = (r_dataOut & r_dir) | (w_sync & ~r_dir);
            ADDR_DIR:     readdata[WIDTH-1:0] = r_dir;
            ADDR_IRQMASK: readdata[WIDTH-1:0] = r_irqMask;
            ADDR_EDGECAP: readdata[WIDTH-1:0] = r_edgeCap;
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_avalon_pio_gpio.sv
// tb_avalon_pio_gpio: directed, scoreboard-based bench for avalon_pio_gpio.
// It uses the default parameters (WIDTH=17, rising-edge capture, 2-stage
// synchroniser). The set/clear expectations follow PIO_BITSET_EN.
module tb_avalon_pio_gpio;

    localparam int WIDTH = 17;
`ifdef PIO_BITSET_EN
    localparam bit BITSET = 1'b1;
`else
    localparam bit BITSET = 1'b0;
`endif

    logic             clk;
    logic             reset_n;
    logic [2:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] in_port;
    logic [WIDTH-1:0] out_port;
    logic [WIDTH-1:0] out_en;
    logic             irq;

    int          vectorCount;
    int          missCount;
    string       tagQ[$];
    logic [31:0] expQ[$];
    logic [31:0] rd;

    avalon_pio_gpio dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .out_en     (out_en),
        .irq        (irq)
    );

    // Free-running clock; the first rising edge occurs at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expected value together with a short tag.
    task automatic pushExpect(input string tag, input logic [31:0] value);
        tagQ.push_back(tag);
        expQ.push_back(value);
    endtask

    // Pop the oldest expectation and compare it with the observed value.
    task automatic checkOutput(input logic [31:0] observed);
        string       tag;
        logic [31:0] expected;
        vectorCount++;
        if (expQ.size() == 0) begin
            missCount++;
            $error("[TB] FAIL scoreboard-empty observed=0x%08h", observed);
        end else begin
            tag      = tagQ.pop_front();
            expected = expQ.pop_front();
            assert (observed === expected) else begin
                missCount++;
                $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
            end
        end
    endtask

    // One bus write. The strobe is driven on a falling edge and is taken on
    // the next rising edge. The task returns on the falling edge that follows.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // Combinational read: present the address, then sample shortly after.
    task automatic readReg(input logic [2:0] addr, output logic [31:0] data);
        address = addr;
        #1;
        data = readdata;
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        reset_n     = 1'b1;
        address     = '0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = '0;
        in_port     = '0;
        #1 reset_n  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        pushExpect("rst-out_port", 32'h0);     checkOutput(32'(out_port));
        pushExpect("rst-out_en", 32'h1FFFF);   checkOutput(32'(out_en));
        pushExpect("rst-irq", 32'h0);          checkOutput(32'(irq));
        pushExpect("rst-rd0", 32'h0);          readReg(3'd0, rd); checkOutput(rd);
        pushExpect("rst-rd1", 32'h0001FFFF);   readReg(3'd1, rd); checkOutput(rd);
        pushExpect("rst-rd2", 32'h0);          readReg(3'd2, rd); checkOutput(rd);
        pushExpect("rst-rd3", 32'h0);          readReg(3'd3, rd); checkOutput(rd);
        pushExpect("rst-rd6", 32'h0);          readReg(3'd6, rd); checkOutput(rd);
        reset_n = 1'b1;

        // Full-width write: upper writedata bits are dropped
        applyStimulus(3'd0, 32'hFFFF_FFFF);
        pushExpect("wr-out_port", 32'h1FFFF);  checkOutput(32'(out_port));
        pushExpect("wr-rd0", 32'h0001FFFF);    readReg(3'd0, rd); checkOutput(rd);
        applyStimulus(3'd7, 32'h1234_5678);
        pushExpect("rsvd7-rd", 32'h0);         readReg(3'd7, rd); checkOutput(rd);
        pushExpect("rsvd7-out", 32'h1FFFF);    checkOutput(32'(out_port));

        // Mixed direction: low nibble is input, the rest is output
        applyStimulus(3'd1, 32'h0001_FFF0);
        applyStimulus(3'd0, 32'h0001_FFF0);
        pushExpect("dir-out_en", 32'h1FFF0);   checkOutput(32'(out_en));
        pushExpect("dir-out_port", 32'h1FFF0); checkOutput(32'(out_port));
        in_port = 17'h0000A;
        repeat (2) @(negedge clk);
        pushExpect("mix-ecap-early", 32'h0);   readReg(3'd3, rd); checkOutput(rd);
        @(negedge clk);
        pushExpect("mix-rd0", 32'h0001FFFA);   readReg(3'd0, rd); checkOutput(rd);
        pushExpect("mix-ecap", 32'h0000000A);  readReg(3'd3, rd); checkOutput(rd);
        pushExpect("mix-irq-masked", 32'h0);   checkOutput(32'(irq));
        applyStimulus(3'd1, 32'h0001_FFFF);
        pushExpect("dirchg-out_port", 32'h1FFF0); checkOutput(32'(out_port));
        in_port = '0;
        repeat (4) @(negedge clk);
        applyStimulus(3'd3, 32'hFFFF_FFFF);
        pushExpect("ecap-clrall", 32'h0);      readReg(3'd3, rd); checkOutput(rd);

        // Rising edge on bit 0 with irq enabled
        applyStimulus(3'd1, 32'h0);
        applyStimulus(3'd2, 32'h1);
        pushExpect("irqmask-rd", 32'h1);       readReg(3'd2, rd); checkOutput(rd);
        in_port = 17'h00001;
        repeat (2) @(negedge clk);
        pushExpect("edge-2clk", 32'h0);        readReg(3'd3, rd); checkOutput(rd);
        @(negedge clk);
        pushExpect("edge-3clk", 32'h1);        readReg(3'd3, rd); checkOutput(rd);
        pushExpect("irq-3clk", 32'h0);         checkOutput(32'(irq));
        @(negedge clk);
        pushExpect("irq-4clk", 32'h1);         checkOutput(32'(irq));
        applyStimulus(3'd3, 32'h1);
        pushExpect("clr-ecap", 32'h0);         readReg(3'd3, rd); checkOutput(rd);
        pushExpect("clr-irq-lag", 32'h1);      checkOutput(32'(irq));
        @(negedge clk);
        pushExpect("clr-irq-low", 32'h0);      checkOutput(32'(irq));

        // Set beats clear in the same cycle
        in_port = '0;
        repeat (4) @(negedge clk);
        in_port = 17'h00001;
        repeat (4) @(negedge clk);
        pushExpect("pre-ecap", 32'h1);         readReg(3'd3, rd); checkOutput(rd);
        pushExpect("pre-irq", 32'h1);          checkOutput(32'(irq));
        in_port = '0;
        repeat (4) @(negedge clk);
        pushExpect("fall-ignored", 32'h1);     readReg(3'd3, rd); checkOutput(rd);
        in_port = 17'h00001;
        @(negedge clk);
        applyStimulus(3'd3, 32'h1);
        pushExpect("setwins-ecap", 32'h1);     readReg(3'd3, rd); checkOutput(rd);
        pushExpect("setwins-irq", 32'h1);      checkOutput(32'(irq));
        @(negedge clk);
        pushExpect("setwins-irq2", 32'h1);     checkOutput(32'(irq));
        applyStimulus(3'd3, 32'h1);
        pushExpect("final-clr", 32'h0);        readReg(3'd3, rd); checkOutput(rd);
        @(negedge clk);
        pushExpect("final-irq", 32'h0);        checkOutput(32'(irq));

        // Atomic set/clear (or reserved behaviour without the feature)
        applyStimulus(3'd0, 32'h0000_00F0);
        applyStimulus(3'd4, 32'h0000_0003);
        pushExpect("outset", BITSET ? 32'hF3 : 32'hF0); checkOutput(32'(out_port));
        applyStimulus(3'd5, 32'h0000_0030);
        pushExpect("outclr", BITSET ? 32'hC3 : 32'hF0); checkOutput(32'(out_port));
        pushExpect("rd4", 32'h0);              readReg(3'd4, rd); checkOutput(rd);
        pushExpect("rd5", 32'h0);              readReg(3'd5, rd); checkOutput(rd);

        // Asynchronous reset in the middle of a write
        applyStimulus(3'd1, 32'h0000_0005);
        @(negedge clk);
        address    = 3'd0;
        writedata  = 32'h0000_1234;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        pushExpect("async-out_port", 32'h0);   checkOutput(32'(out_port));
        pushExpect("async-out_en", 32'h1FFFF); checkOutput(32'(out_en));
        pushExpect("async-irq", 32'h0);        checkOutput(32'(irq));
        chipselect = 1'b0;
        write_n    = 1'b1;
        pushExpect("async-irqmask", 32'h0);    readReg(3'd2, rd); checkOutput(rd);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        pushExpect("post-rst-out", 32'h0);     checkOutput(32'(out_port));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
